// File: rtl/bconv_relu_pool.sv
// bconv_relu_pool: streaming KSIZE x KSIZE +/-1-weight conv, ReLU and 2x2 max-pool with valid/ready input.
// Optional macro BCONV_BIAS_EN adds a per-frame bias input added before ReLU.
module bconv_relu_pool #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int KSIZE  = 5,
  parameter int ACC_W  = DATA_W + 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              weight_en,
  input  logic              weight,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
`ifdef BCONV_BIAS_EN
  input  logic [ACC_W-1:0]  bias,
`endif
  output logic              din_ready,
  output logic [ACC_W-1:0]  dout,
  output logic              ovalid,
  output logic              busy,
  output logic              done
);
  localparam int K2 = KSIZE * KSIZE;
  localparam int OW = IMG_W - KSIZE + 1;
  localparam int OH = IMG_H - KSIZE + 1;
  localparam int PW = OW / 2;
  localparam int PH = OH / 2;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int JW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [CW-1:0] C_LO  = CW'(KSIZE - 1);
  localparam logic [CW-1:0] C_HI  = CW'(KSIZE - 2 + 2 * PW);
  localparam logic [CW-1:0] C_END = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LO  = RW'(KSIZE - 1);
  localparam logic [RW-1:0] R_HI  = RW'(KSIZE - 2 + 2 * PH);
  localparam logic [RW-1:0] R_END = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic              dcnt_q, dcnt_d;
  logic [K2-1:0]     w_q, w_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] lb_q [KSIZE-1][IMG_W];
  logic [DATA_W-1:0] lb_d [KSIZE-1][IMG_W];
  logic [DATA_W-1:0] win_q [KSIZE][KSIZE-1];
  logic [DATA_W-1:0] win_d [KSIZE][KSIZE-1];
  logic [DATA_W-1:0] win [KSIZE][KSIZE];
  logic [ACC_W-1:0]  acc_q, acc_d, relu_q, relu_d, dout_q, dout_d, hmax_q, hmax_d;
  logic [ACC_W-1:0]  pbuf_q [PW];
  logic [ACC_W-1:0]  pbuf_d [PW];
  logic [ACC_W-1:0]  biased, pair;
  logic              v1_q, v1_d, r1_q, r1_d, c1_q, c1_d, v2_q, v2_d, r2_q, r2_d, c2_q, c2_d;
  logic [JW-1:0]     j1_q, j1_d, j2_q, j2_d;
  logic              ovalid_q, ovalid_d;
  logic              accept, last_px;

  function automatic logic [ACC_W-1:0] sx(input logic [DATA_W-1:0] p);
    return {{(ACC_W-DATA_W){p[DATA_W-1]}}, p};
  endfunction

  assign accept    = (state_q == RUN) && din_valid;
  assign last_px   = (col_q == C_END) && (row_q == R_END);
  assign din_ready = state_q == RUN;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = state_q == DONE;
  assign dout      = dout_q;
  assign ovalid    = ovalid_q;

  always_comb begin
    state_d = state_q;
    dcnt_d  = 1'b0;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = (accept && last_px) ? DRAIN : RUN;
      DRAIN: begin
        state_d = dcnt_q ? DONE : DRAIN;
        dcnt_d  = ~dcnt_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Full window: stored columns plus the column completed by the incoming pixel.
  always_comb begin
    for (int r = 0; r < KSIZE; r++)
      for (int c = 0; c < KSIZE - 1; c++) win[r][c] = win_q[r][c];
    for (int r = 0; r < KSIZE - 1; r++) win[r][KSIZE-1] = lb_q[KSIZE-2-r][col_q];
    win[KSIZE-1][KSIZE-1] = din;
  end

  always_comb begin
    acc_d = '0;
    for (int r = 0; r < KSIZE; r++)
      for (int c = 0; c < KSIZE; c++)
        acc_d = w_q[K2-1-(r*KSIZE+c)] ? acc_d + sx(win[r][c]) : acc_d - sx(win[r][c]);
  end

  always_comb begin
    w_d   = (state_q == IDLE && weight_en) ? {w_q[K2-2:0], weight} : w_q;
    col_d = col_q;
    row_d = row_q;
    lb_d  = lb_q;
    win_d = win_q;
    if (accept) begin
      col_d = (col_q == C_END) ? '0 : col_q + 1'b1;
      row_d = (col_q != C_END) ? row_q : (row_q == R_END) ? '0 : row_q + 1'b1;
      lb_d[0][col_q] = din;
      for (int k = 1; k < KSIZE - 1; k++) lb_d[k][col_q] = lb_q[k-1][col_q];
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE - 1; c++) win_d[r][c] = win[r][c+1];
    end
  end

`ifdef BCONV_BIAS_EN
  logic [ACC_W-1:0] bias_q, bias_d;
  always_comb bias_d = (state_q == IDLE && start) ? bias : bias_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) bias_q <= '0;
    else     bias_q <= bias_d;
  assign biased = acc_q + bias_q;
`else
  assign biased = acc_q;
`endif

  // Pool pipeline tags: only conv outputs inside the even-sized pooling grid are marked valid.
  always_comb begin
    v1_d     = accept && row_q >= R_LO && row_q <= R_HI && col_q >= C_LO && col_q <= C_HI;
    r1_d     = row_q[0] ^ R_LO[0];
    c1_d     = col_q[0] ^ C_LO[0];
    j1_d     = JW'((col_q - C_LO) >> 1);
    v2_d     = v1_q;
    r2_d     = r1_q;
    c2_d     = c1_q;
    j2_d     = j1_q;
    relu_d   = biased[ACC_W-1] ? '0 : biased;
    pair     = (hmax_q > relu_q) ? hmax_q : relu_q;
    hmax_d   = (v2_q && !c2_q) ? relu_q : hmax_q;
    pbuf_d   = pbuf_q;
    if (v2_q && c2_q && !r2_q) pbuf_d[j2_q] = pair;
    ovalid_d = v2_q && c2_q && r2_q;
    dout_d   = !ovalid_d ? dout_q : (pbuf_q[j2_q] > pair) ? pbuf_q[j2_q] : pair;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      dcnt_q   <= 1'b0;
      w_q      <= '1;
      col_q    <= '0;
      row_q    <= '0;
      lb_q     <= '{default: '0};
      win_q    <= '{default: '0};
      acc_q    <= '0;
      relu_q   <= '0;
      dout_q   <= '0;
      hmax_q   <= '0;
      pbuf_q   <= '{default: '0};
      v1_q     <= 1'b0;
      r1_q     <= 1'b0;
      c1_q     <= 1'b0;
      j1_q     <= '0;
      v2_q     <= 1'b0;
      r2_q     <= 1'b0;
      c2_q     <= 1'b0;
      j2_q     <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      w_q      <= w_d;
      col_q    <= col_d;
      row_q    <= row_d;
      lb_q     <= lb_d;
      win_q    <= win_d;
      acc_q    <= acc_d;
      relu_q   <= relu_d;
      dout_q   <= dout_d;
      hmax_q   <= hmax_d;
      pbuf_q   <= pbuf_d;
      v1_q     <= v1_d;
      r1_q     <= r1_d;
      c1_q     <= c1_d;
      j1_q     <= j1_d;
      v2_q     <= v2_d;
      r2_q     <= r2_d;
      c2_q     <= c2_d;
      j2_q     <= j2_d;
      ovalid_q <= ovalid_d;
    end
endmodule

// File: tb/tb_bconv_relu_pool.sv
// tb_bconv_relu_pool: randomized frames on a 7x7/K3 instance checked against an array-based conv/ReLU/pool model.
module tb_bconv_relu_pool;
  localparam int DW = 8, IW = 7, IH = 7, KS = 3, AW = 14;
  localparam int OW = IW - KS + 1, OH = IH - KS + 1, PW = OW / 2, PH = OH / 2;

  logic clk = 0, rst = 1, start = 0, weight_en = 0, weight = 0, din_valid = 0;
  logic [DW-1:0] din = '0;
  logic din_ready, ovalid, busy, done;
  logic [AW-1:0] dout;
`ifdef BCONV_BIAS_EN
  logic [AW-1:0] bias_in = '0;
`endif

  int checks = 0, failures = 0, cyc = 0, exp_done = -1, bias_val = 0;
  typedef struct {int val; int cyc;} exp_t;
  exp_t q[$];
  int img[IH][IW];
  int conv[OH][OW];
  int expv[IH][IW];
  bit trig[IH][IW];
  int wt[KS*KS];

  bconv_relu_pool #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .KSIZE(KS), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .weight_en(weight_en), .weight(weight),
    .din(din), .din_valid(din_valid),
`ifdef BCONV_BIAS_EN
    .bias(bias_in),
`endif
    .din_ready(din_ready), .dout(dout), .ovalid(ovalid), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every ovalid pops one expected word; done must land on the predicted cycle.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (ovalid) begin
        if (q.size() == 0) chk("unexpected_ovalid", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("dout", int'(dout), e.val);
          chk("ovalid_latency", cyc, e.cyc);
        end
      end
      if (done) chk("done_cycle", cyc, exp_done);
    end
  end

  task automatic build_model();
    int s, m;
    for (int cr = 0; cr < OH; cr++)
      for (int cc = 0; cc < OW; cc++) begin
        s = bias_val;
        for (int i = 0; i < KS; i++)
          for (int j = 0; j < KS; j++) s += wt[i*KS+j] * img[cr+i][cc+j];
        conv[cr][cc] = (s < 0) ? 0 : s;
      end
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) trig[r][c] = 0;
    for (int pi = 0; pi < PH; pi++)
      for (int pj = 0; pj < PW; pj++) begin
        m = 0;
        for (int a = 0; a < 2; a++)
          for (int b = 0; b < 2; b++)
            if (conv[2*pi+a][2*pj+b] > m) m = conv[2*pi+a][2*pj+b];
        trig[KS-1+2*pi+1][KS-1+2*pj+1] = 1;
        expv[KS-1+2*pi+1][KS-1+2*pj+1] = m;
      end
  endtask

  task automatic load_w(input logic [KS*KS-1:0] bits);
    for (int k = 0; k < KS*KS; k++) begin
      @(negedge clk);
      weight_en = 1;
      weight = bits[k];
      wt[k] = bits[k] ? 1 : -1;
    end
    @(negedge clk);
    weight_en = 0;
  endtask

  // pat: 0 random, 1 all ones, 2 row*IW+col. mode: 0 valid always, 1 alternate, 2 random + noise.
  task automatic run_frame(input int pat, input int mode, input int abort_at);
    int idx, budget, r, c, n;
    bit busy_bad;
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++)
        img[y][x] = (pat == 1) ? 1 : (pat == 2) ? y * IW + x : int'($urandom_range(0, 255)) - 128;
`ifdef BCONV_BIAS_EN
    bias_val = int'($urandom_range(0, 60)) - 30;
    bias_in = AW'(bias_val);
`endif
    build_model();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    idx = 0;
    budget = 0;
    busy_bad = 0;
    while (idx < IW * IH && budget < 2000) begin
      budget++;
      din_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (budget % 2 == 1) : ($urandom_range(0, 2) != 0);
      r = idx / IW;
      c = idx % IW;
      din = DW'(img[r][c]);
      if (mode == 2) begin
        start = ($urandom_range(0, 7) == 0);
        weight_en = ($urandom_range(0, 5) == 0);
        weight = 1'($urandom_range(0, 1));
      end
      if (!busy) busy_bad = 1;
      if (din_valid && din_ready) begin
        if (trig[r][c]) q.push_back('{expv[r][c], cyc + 3});
        idx++;
        if (idx == IW * IH) exp_done = cyc + 3;
      end
      @(negedge clk);
      if (abort_at != 0 && idx == abort_at) break;
    end
    din_valid = 0;
    start = 0;
    weight_en = 0;
    if (abort_at != 0) begin
      rst = 1;
      #1;
      chk("abort_dout", int'(dout), 0);
      chk("abort_ovalid", int'(ovalid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_din_ready", int'(din_ready), 0);
      q.delete();
      exp_done = -1;
      for (int k = 0; k < KS*KS; k++) wt[k] = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (12) @(negedge clk);
      chk("abort_idle", int'(busy), 0);
      return;
    end
    chk("frame_accepts", idx, IW * IH);
    n = 0;
    while (!done && n < 20) begin
      if (!busy) busy_bad = 1;
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(done), 1);
    chk("busy_during_frame", int'(busy_bad), 0);
    if (mode == 2) start = 1;
    @(negedge clk);
    start = 0;
    chk("done_pulse_width", int'(done), 0);
    chk("busy_after_done", int'(busy), 0);
    chk("queue_drained", q.size(), 0);
    exp_done = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < KS*KS; k++) wt[k] = 1;
    repeat (3) @(negedge clk);
    chk("reset_dout", int'(dout), 0);
    chk("reset_ovalid", int'(ovalid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_din_ready", int'(din_ready), 0);
    rst = 0;
    @(negedge clk);
    chk("idle_din_ready", int'(din_ready), 0);
    run_frame(1, 0, 0);
    load_w('0);
    run_frame(1, 0, 0);
    load_w(9'($urandom));
    run_frame(0, 1, 0);
    load_w(9'($urandom));
    run_frame(0, 2, 0);
    load_w('1);
    run_frame(2, 0, 0);
    load_w(9'($urandom));
    run_frame(0, 0, 20);
    run_frame(0, 2, 0);
    load_w(9'($urandom));
    run_frame(0, 1, 0);
    run_frame(0, 0, 0);
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
